// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode seven-segment scanner. Advances one digit per rising
// edge of the divided clock (sampled as data) and shows a per-frame snapshot of value_in.
module seg7_scan_driver #(
  parameter int         NUM_DIGITS = 8,
  parameter bit         BLANK_LZ   = 1'b1,
  parameter logic [7:0] DP_MASK    = 8'h00
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick_in,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic [6:0]                seg_n,
  output logic                      dp_n,
  output logic                      frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    tick_prev;
  logic [IDX_W-1:0]        digit_idx;
  logic [4*NUM_DIGITS-1:0] snapshot;

  logic                    rise;
  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic                    zero_acc;
  logic [NUM_DIGITS-1:0]   an_sel;

  assign rise = tick_in & ~tick_prev;
  assign wrap = (digit_idx == IDX_W'(NUM_DIGITS - 1));

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Walk from the top digit down so zero_acc means "this nibble and all above are zero".
  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    an_sel    = '1;
    zero_acc  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc = zero_acc & (snapshot[4*i +: 4] == 4'h0);
      if (digit_idx == IDX_W'(i)) begin
        cur_nib   = snapshot[4*i +: 4];
        cur_blank = BLANK_LZ && (i != 0) && zero_acc;
        cur_dp    = DP_MASK[i];
        an_sel[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_prev  <= 1'b1;
      digit_idx  <= '0;
      snapshot   <= '0;
      an_n       <= '1;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      tick_prev  <= tick_in;
      frame_done <= 1'b0;
      if (rise && enable) begin
        if (wrap) begin
          digit_idx  <= '0;
          snapshot   <= value_in;
          frame_done <= 1'b1;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end
      if (enable && !cur_blank) begin
        an_n  <= an_sel;
        seg_n <= hex7(cur_nib);
        dp_n  <= ~cur_dp;
      end else begin
        an_n  <= '1;
        seg_n <= 7'h7F;
        dp_n  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a behavioural scan model pushes expected
// display words into queues as each tick is driven; they are popped once the DUT output settles.
module tb_seg7_scan_driver;

  localparam int         N   = 8;
  localparam logic [7:0] DPM = 8'h05;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick_in = 1'b1;
  logic          enable = 1'b1;
  logic [4*N-1:0] value_in = '0;

  logic [N-1:0]  an_n, an_n_nb;
  logic [6:0]    seg_n, seg_n_nb;
  logic          dp_n, dp_n_nb;
  logic          frame_done, frame_done_nb;

  seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_LZ(1'b1), .DP_MASK(DPM)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .enable(enable), .value_in(value_in),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_done(frame_done)
  );

  seg7_scan_driver #(.NUM_DIGITS(N), .BLANK_LZ(1'b0), .DP_MASK(8'h00)) dut_nb (
    .clk(clk), .reset(reset), .tick_in(tick_in), .enable(enable), .value_in(value_in),
    .an_n(an_n_nb), .seg_n(seg_n_nb), .dp_n(dp_n_nb), .frame_done(frame_done_nb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_nb_q[$];
  int          m_idx;
  logic [31:0] m_snap;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [15:0] disp(input int idx, input logic [31:0] snap, input logic en,
                                       input bit blz, input logic [7:0] dpm);
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    bit         blank;
    an  = 8'hFF;
    seg = 7'h7F;
    dp  = 1'b1;
    blank = blz && (idx > 0) && ((snap >> (4 * idx)) == 32'h0);
    if (en && !blank) begin
      an[idx] = 1'b0;
      seg     = hex7(snap[4*idx +: 4]);
      dp      = ~dpm[idx];
    end
    return {an, seg, dp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_q.push_back(disp(m_idx, m_snap, enable, 1'b1, DPM));
    exp_nb_q.push_back(disp(m_idx, m_snap, enable, 1'b0, 8'h00));
  endtask

  task automatic compare_disp(input string tag);
    if (exp_q.size() == 0 || exp_nb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=output expected=queued_entry", tag);
    end else begin
      chk(tag, {an_n, seg_n, dp_n}, exp_q.pop_front());
      chk({tag, "_nb"}, {an_n_nb, seg_n_nb, dp_n_nb}, exp_nb_q.pop_front());
    end
  endtask

  // One tick_in pulse held high for high_cycles clocks, then low for one clock.
  task automatic pulse(input int high_cycles, input string tag);
    logic fd;
    fd = enable && (m_idx == N - 1);
    if (enable) begin
      if (fd) begin
        m_snap = value_in;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    push_exp();
    tick_in = 1'b1;
    step();
    chk({tag, "_fd"}, 16'(frame_done), 16'(fd));
    chk({tag, "_fd_nb"}, 16'(frame_done_nb), 16'(fd));
    for (int k = 1; k < high_cycles; k++) step();
    if (high_cycles > 1) chk({tag, "_fd_held"}, 16'(frame_done), 16'h0);
    tick_in = 1'b0;
    step();
    compare_disp(tag);
  endtask

  initial begin
    // Reset with tick_in already high.
    reset = 1'b1; tick_in = 1'b1; enable = 1'b1; value_in = '0;
    repeat (3) step();
    chk("reset_disp", {an_n, seg_n, dp_n}, {8'hFF, 7'h7F, 1'b1});
    chk("reset_fd", 16'(frame_done), 16'h0);
    m_idx = 0;
    m_snap = '0;
    reset = 1'b0;
    push_exp();
    step();
    compare_disp("release");
    chk("release_an", 16'(an_n), 16'h00FE);
    chk("release_seg", 16'(seg_n), 16'h0040);
    for (int k = 0; k < 4; k++) begin
      push_exp();
      step();
      compare_disp("held_high");
    end
    tick_in = 1'b0;
    step();

    // Two frames of 0x004012AF, the first pulse held high for several clocks.
    value_in = 32'h0040_12AF;
    pulse(5, "long_high");
    for (int k = 0; k < 15; k++) pulse(1, "frame");
    chk("digit0_F", 16'(seg_n), 16'h000E);

    // Mid-frame value change must not tear the display.
    for (int k = 0; k < 3; k++) pulse(1, "pre_change");
    value_in = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) pulse(1, "old_snap");
    for (int k = 0; k < 7; k++) pulse(1, "new_snap");
    chk("digit7_D", 16'(seg_n), 16'h0021);
    pulse(1, "wrap");

    // Enable gap: dark output, ticks discarded, scan resumes at the frozen index.
    pulse(1, "pre_gap");
    pulse(1, "pre_gap");
    enable = 1'b0;
    push_exp();
    step();
    compare_disp("dark");
    for (int k = 0; k < 5; k++) pulse(1, "gap");
    enable = 1'b1;
    push_exp();
    step();
    compare_disp("resume");
    chk("resume_an", 16'(an_n), 16'h00FB);
    pulse(1, "resume_tick");

    // Zero value: only digit 0 lit with blanking, all digits show 0 without.
    value_in = '0;
    for (int k = 0; k < 5; k++) pulse(1, "to_zero");
    chk("zero_d0_an", 16'(an_n), 16'h00FE);
    for (int k = 0; k < 8; k++) pulse(1, "zero_frame");

    // Reset mid-frame coinciding with a rise.
    value_in = 32'h1234_5678;
    for (int k = 0; k < 5; k++) pulse(1, "pre_reset");
    reset = 1'b1;
    tick_in = 1'b1;
    step();
    chk("midreset_disp", {an_n, seg_n, dp_n}, {8'hFF, 7'h7F, 1'b1});
    chk("midreset_fd", 16'(frame_done), 16'h0);
    m_idx = 0;
    m_snap = '0;
    reset = 1'b0;
    tick_in = 1'b0;
    push_exp();
    step();
    compare_disp("post_reset");
    pulse(1, "post_reset_tick");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
